vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//   Parametrised raster timing generator for the video path. Produces pixel/line counters,
//   active-video and sync strobes, and line/frame start pulses for any CVT/DMT-style mode.
//   A configurable delay pipeline aligns sync/active with downstream pixel-fetch latency.
//   Sits between the pixel clock domain root and the framebuffer reader/DAC output stage.
// PARAMETERS
//   H_ACTIVE  640  visible pixels per line
//   H_FP      16   horizontal front porch (pixels)
//   H_SYNC    96   hsync width (pixels)
//   H_BP      48   horizontal back porch (pixels)
//   V_ACTIVE  480  visible lines per frame
//   V_FP      10   vertical front porch (lines)
//   V_SYNC    2    vsync width (lines)
//   V_BP      33   vertical back porch (lines)
//   H_POL     1    hsync level during sync pulse (1 = active-high)
//   V_POL     1    vsync level during sync pulse
//   CNT_W     11   counter width; must hold H_TOTAL-1 and V_TOTAL-1
//   PIPE_DLY  0    extra output register stages (0..7) beyond the mandatory one
// PORTS
//   pix_clk      in   1      pixel clock
//   reset_n      in   1      asynchronous active-low reset
//   pix_en       in   1      pixel advance enable; low freezes counters and pipeline
//   hcount       out  CNT_W  raw horizontal counter (registered, undelayed)
//   vcount       out  CNT_W  raw vertical counter (registered, undelayed)
//   x_pos        out  CNT_W  hcount delayed to align with active/hsync
//   y_pos        out  CNT_W  vcount delayed to align with active/vsync
//   active       out  1      visible-region strobe, delayed
//   hsync        out  1      horizontal sync, polarity H_POL, delayed
//   vsync        out  1      vertical sync, polarity V_POL, delayed
//   line_start   out  1      1-enabled-cycle pulse at hcount==0 (every line), delayed
//   frame_start  out  1      1-enabled-cycle pulse at hcount==0 && vcount==0, delayed
// BEHAVIOUR
//   - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
//   - Reset (async assert, sync release): hcount=vcount=x_pos=y_pos=0, active=0,
//     line_start=frame_start=0, hsync=~H_POL, vsync=~V_POL; all pipeline stages likewise.
//   - On pix_clk rise with pix_en=1: hcount increments; at H_TOTAL-1 wraps to 0 and vcount
//     increments; vcount at V_TOTAL-1 with hcount wrap wraps to 0. pix_en=0: all state held.
//   - Decode from raw counters: act = hcount<H_ACTIVE && vcount<V_ACTIVE;
//     hs = hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) (656..751);
//     vs = vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC) (490..491).
//   - Latency: decoded signals and x_pos/y_pos appear 1+PIPE_DLY enabled cycles after the
//     counter value they describe. All delayed outputs move together; never skewed.
//   - Pipeline advances only when pix_en=1; pulses stay high while pix_en low (held), and
//     downstream qualifies pulses with pix_en.
//   - Comparisons unsigned at CNT_W bits; no signed arithmetic. Elaboration error if
//     H_TOTAL or V_TOTAL exceeds 2**CNT_W, or PIPE_DLY > 7.
//   - Reset mid-frame: counters and pipeline clear immediately; first enabled cycle after
//     release is hcount=1, and frame_start appears 1+PIPE_DLY enabled cycles after release.
// STRUCTURE
//   - Shared package vga_pkg: mode timing constants (640x480@60, 800x600@60) as localparams,
//     struct vga_timing_t {act, hs, vs, ls, fs, x, y} carried through the pipeline.
//   - One sub-module: vga_delay_line (DEPTH, W) — enabled shift register with async reset
//     to a RESET_VAL parameter; instanced once on the packed vga_timing_t.
// TESTING
//   - Defaults, pix_en=1, run 2 frames -> hcount period 800, vcount period 525, 420000 clk/frame.
//   - Defaults, PIPE_DLY=0 -> active rises 1 cycle after hcount=0,vcount=0; hsync high for
//     exactly 96 cycles starting 1 cycle after hcount=656; vsync high lines 490-491.
//   - PIPE_DLY=3 -> active/hsync/x_pos lag the PIPE_DLY=0 instance by exactly 3 cycles; x_pos=0
//     coincides with active rising edge.
//   - pix_en toggled 1/0 every cycle -> counters advance on enabled cycles only; frame period
//     840000 clk; pulses never counted twice when qualified with pix_en.
//   - Assert reset_n low at hcount=300,vcount=200 -> all outputs at reset values same cycle;
//     after release frame_start pulses once, 1+PIPE_DLY enabled cycles later.
//   - H_POL=0,V_POL=0 -> hsync/vsync idle high, low during pulse; reset value 1.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared mode constants and the timing record carried through the output pipeline
package vga_pkg;
  localparam int XY_W = 16;
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;
  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FP     = 40;
  localparam int SVGA800_H_SYNC   = 128;
  localparam int SVGA800_H_BP     = 88;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FP     = 1;
  localparam int SVGA800_V_SYNC   = 4;
  localparam int SVGA800_V_BP     = 23;
  typedef struct packed {
    logic            act;
    logic            hs;
    logic            vs;
    logic            ls;
    logic            fs;
    logic [XY_W-1:0] x;
    logic [XY_W-1:0] y;
  } vga_timing_t;
  function automatic int vga_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction
endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing bundle between the generator and video consumers
interface vga_timing_gen_if #(
  parameter int CNT_W = 11
);
  logic             pix_en;
  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;
  logic [CNT_W-1:0] x_pos;
  logic [CNT_W-1:0] y_pos;
  logic             active;
  logic             hsync;
  logic             vsync;
  logic             line_start;
  logic             frame_start;
  modport master (
    input  pix_en,
    output hcount, vcount, x_pos, y_pos, active, hsync, vsync, line_start, frame_start
  );
  modport slave (
    output pix_en,
    input  hcount, vcount, x_pos, y_pos, active, hsync, vsync, line_start, frame_start
  );
endinterface

// File: rtl/vga_delay_line.sv
// vga_delay_line: enabled shift register with asynchronous reset to a fixed value
module vga_delay_line #(
  parameter int           DEPTH     = 1,
  parameter int           W         = 1,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] stage [DEPTH];
  // shift one stage per enabled clock; disabled clocks hold every stage
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
    end else if (en) begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  assign q = stage[DEPTH-1];
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters, sync/active decode and latency-aligned output pipeline
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b1,
  parameter bit V_POL    = 1'b1,
  parameter int CNT_W    = 11,
  parameter int PIPE_DLY = 0
) (
  input logic              pix_clk,
  input logic              reset_n,
  vga_timing_gen_if.master vid
);
  localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  // thresholds carry one spare bit so a boundary equal to 2**CNT_W still compares correctly
  localparam logic [CNT_W:0] H_LAST  = (CNT_W+1)'(H_TOTAL - 1);
  localparam logic [CNT_W:0] V_LAST  = (CNT_W+1)'(V_TOTAL - 1);
  localparam logic [CNT_W:0] H_ACT_E = (CNT_W+1)'(H_ACTIVE);
  localparam logic [CNT_W:0] V_ACT_E = (CNT_W+1)'(V_ACTIVE);
  localparam logic [CNT_W:0] HS_BEG  = (CNT_W+1)'(H_ACTIVE + H_FP);
  localparam logic [CNT_W:0] HS_END  = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W:0] VS_BEG  = (CNT_W+1)'(V_ACTIVE + V_FP);
  localparam logic [CNT_W:0] VS_END  = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam vga_timing_t RST_T = '{act: 1'b0, hs: ~H_POL, vs: ~V_POL, ls: 1'b0, fs: 1'b0,
                                    x: '0, y: '0};
  if (H_TOTAL > 2**CNT_W || V_TOTAL > 2**CNT_W || CNT_W > XY_W || PIPE_DLY < 0 || PIPE_DLY > 7)
  begin : g_bad_cfg
    $error("vga_timing_gen: illegal timing parameters");
  end
  logic [CNT_W-1:0] hcount, vcount;
  logic [CNT_W:0]   h, v;
  logic             h_wrap, v_wrap;
  vga_timing_t      cur, dly;
  logic             unused_xy_hi;
  assign h      = {1'b0, hcount};
  assign v      = {1'b0, vcount};
  assign h_wrap = h == H_LAST;
  assign v_wrap = v == V_LAST;
  // raster position: pixel counter wraps into the line counter, both frozen while pix_en is low
  always_ff @(posedge pix_clk or negedge reset_n)
    if (!reset_n) begin
      hcount <= '0;
      vcount <= '0;
    end else if (vid.pix_en) begin
      hcount <= h_wrap ? '0 : hcount + 1'b1;
      if (h_wrap) vcount <= v_wrap ? '0 : vcount + 1'b1;
    end
  // decode the raw position into the record that travels down the pipeline
  always_comb begin
    cur.act = h < H_ACT_E && v < V_ACT_E;
    cur.hs  = (h >= HS_BEG && h < HS_END) ? H_POL : ~H_POL;
    cur.vs  = (v >= VS_BEG && v < VS_END) ? V_POL : ~V_POL;
    cur.ls  = hcount == '0;
    cur.fs  = hcount == '0 && vcount == '0;
    cur.x   = XY_W'(hcount);
    cur.y   = XY_W'(vcount);
  end
  vga_delay_line #(
    .DEPTH    (PIPE_DLY + 1),
    .W        ($bits(vga_timing_t)),
    .RESET_VAL(RST_T)
  ) u_dly (
    .clk  (pix_clk),
    .rst_n(reset_n),
    .en   (vid.pix_en),
    .d    (cur),
    .q    (dly)
  );
  assign unused_xy_hi    = ^{dly.x, dly.y};
  assign vid.hcount      = hcount;
  assign vid.vcount      = vcount;
  assign vid.x_pos       = CNT_W'(dly.x);
  assign vid.y_pos       = CNT_W'(dly.y);
  assign vid.active      = dly.act;
  assign vid.hsync       = dly.hs;
  assign vid.vsync       = dly.vs;
  assign vid.line_start  = dly.ls;
  assign vid.frame_start = dly.fs;
endmodule
